// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - widths, types and reset constants for the register file (RF_BYPASS_EN selects write-first reads in rf_multiport)
package rf_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    // $s0 comes out of reset holding the data-memory base pointer
    localparam int                   INIT_IDX = 16;
    localparam logic [DEF_XLEN-1:0]  INIT_VAL = 32'h17;

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

    localparam int DEF_AW = addr_width(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write bitmap, set at issue and cleared at writeback
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    localparam int AW   = addr_width(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic [1:0]           clr_en,
    input  logic [1:0][AW-1:0]   clr_addr,
    output logic [NREGS-1:0]     busy_q
);

    logic [NREGS-1:0] busy_next;

    // Set is applied after the clears so a fresh issue outlives a same-cycle writeback
    always_comb begin
        busy_next = busy_q;
        for (int k = 0; k < 2; k++) begin
            if (clr_en[k]) begin
                busy_next[clr_addr[k]] = 1'b0;
            end
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - NRD-read / 2-write register file with scoreboard and debug tap; define RF_BYPASS_EN for write-first reads
module rf_multiport #(
    parameter int               XLEN     = rf_pkg::DEF_XLEN,
    parameter int               NREGS    = rf_pkg::DEF_NREGS,
    parameter int               NRD      = 2,
    parameter int               INIT_IDX = rf_pkg::INIT_IDX,
    parameter logic [XLEN-1:0]  INIT_VAL = rf_pkg::INIT_VAL,
    localparam int              AW       = rf_pkg::addr_width(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRD-1:0]              rd_en,
    input  logic [NRD-1:0][AW-1:0]      rd_addr,
    output logic [NRD-1:0][XLEN-1:0]    rd_data,
    input  logic [1:0]                  wr_en,
    input  logic [1:0][AW-1:0]          wr_addr,
    input  logic [1:0][XLEN-1:0]        wr_data,
    input  logic                        busy_set,
    input  logic [AW-1:0]               busy_set_addr,
    output logic [NREGS-1:0]            busy_q,
    input  logic [AW-1:0]               dbg_addr,
    output logic [XLEN-1:0]             dbg_data
);
    import rf_pkg::*;

    localparam logic [AW-1:0] INIT_A = AW'(INIT_IDX);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NRD-1:0][XLEN-1:0]   rd_next;

    // r0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk) begin
        if (rst) begin
            regs         <= '0;
            regs[INIT_A] <= INIT_VAL;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k] && (wr_addr[k] != '0)) begin
                    regs[wr_addr[k]] <= wr_data[k];
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_next[p] = regs[rd_addr[p]];
`ifdef RF_BYPASS_EN
            // Port 1 is checked last so its data wins when both ports hit
            if (rd_addr[p] != '0) begin
                if (wr_en[0] && (wr_addr[0] == rd_addr[p])) begin
                    rd_next[p] = wr_data[0];
                end
                if (wr_en[1] && (wr_addr[1] == rd_addr[p])) begin
                    rd_next[p] = wr_data[1];
                end
            end
`else
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    rd_data[p] <= rd_next[p];
                end
            end
        end
    end

    assign dbg_data = regs[dbg_addr];

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (busy_set),
        .set_addr (busy_set_addr),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .busy_q   (busy_q)
    );

endmodule
